// File: rtl/touch_stroke_renderer.sv
// Turns FT6206 touch samples into VRAM pixel writes: background fill on reset/clear,
// isolated dots on pen-down, and gap-free Bresenham segments between successive points.
module touch_stroke_renderer #(
    parameter int            DISPLAY_WIDTH  = 240,
    parameter int            DISPLAY_HEIGHT = 320,
    parameter int            VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter logic [15:0]   BG_COLOR       = 16'h000F,
    parameter logic [15:0]   INK_COLOR      = 16'hFC18,
    localparam int           AW             = $clog2(VRAM_L)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          touch_valid,
    input  logic [8:0]    touch_x,
    input  logic [8:0]    touch_y,
    input  logic          clear,
    output logic          vram_wr_ena,
    output logic [AW-1:0] vram_wr_addr,
    output logic [15:0]   vram_wr_data,
    output logic          busy
);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LINE} state_t;

    localparam logic [9:0]    W_LIM   = 10'(DISPLAY_WIDTH);
    localparam logic [9:0]    H_LIM   = 10'(DISPLAY_HEIGHT);
    localparam logic [17:0]   W18     = 18'(DISPLAY_WIDTH);
    localparam logic [AW-1:0] CLR_TOP = AW'(VRAM_L - 1);

    state_t             state, state_nxt;
    logic               pen_down, pen_nxt;
    logic [8:0]         last_x, last_y, lx_nxt, ly_nxt;
    logic [8:0]         cx, cy, ex, ey, cx_nxt, cy_nxt, ex_nxt, ey_nxt;
    logic signed [9:0]  dx, dy, dx_nxt, dy_nxt;
    logic signed [1:0]  sx, sy, sx_nxt, sy_nxt;
    logic signed [10:0] err, err_nxt;
    logic [AW-1:0]      clr_cnt, clr_nxt;
    logic               we_nxt;
    logic [AW-1:0]      wa_nxt;
    logic [15:0]        wd_nxt;

    logic               in_range, step_x, step_y;
    logic signed [9:0]  ddx, ddy, adx, ady;
    logic signed [11:0] e2, dx12, dy12, ndy12, err12, err_upd;
    logic [17:0]        touch_addr, cur_addr;

    // Full-width address products; the range check guarantees they fit in AW bits.
    assign touch_addr = 18'(touch_y) * W18 + 18'(touch_x);
    assign cur_addr   = 18'(cy) * W18 + 18'(cx);

    assign in_range = ({1'b0, touch_x} < W_LIM) && ({1'b0, touch_y} < H_LIM);
    assign ddx      = $signed({1'b0, touch_x}) - $signed({1'b0, last_x});
    assign ddy      = $signed({1'b0, touch_y}) - $signed({1'b0, last_y});
    assign adx      = ddx[9] ? -ddx : ddx;
    assign ady      = ddy[9] ? -ddy : ddy;

    assign e2     = {err, 1'b0};
    assign dx12   = {{2{dx[9]}}, dx};
    assign dy12   = {{2{dy[9]}}, dy};
    assign ndy12  = -dy12;
    assign err12  = {err[10], err};
    assign step_x = e2 > ndy12;
    assign step_y = e2 < dx12;

    // Both error corrections are decided from the pre-update err.
    always_comb begin
        err_upd = err12;
        if (step_x) err_upd = err_upd - dy12;
        if (step_y) err_upd = err_upd + dx12;
    end

    always_comb begin
        state_nxt = state;
        pen_nxt   = pen_down;
        lx_nxt    = last_x;
        ly_nxt    = last_y;
        cx_nxt    = cx;
        cy_nxt    = cy;
        ex_nxt    = ex;
        ey_nxt    = ey;
        dx_nxt    = dx;
        dy_nxt    = dy;
        sx_nxt    = sx;
        sy_nxt    = sy;
        err_nxt   = err;
        clr_nxt   = clr_cnt;
        we_nxt    = 1'b0;
        wa_nxt    = vram_wr_addr;
        wd_nxt    = vram_wr_data;

        case (state)
            S_CLEAR: begin
                we_nxt = 1'b1;
                wa_nxt = clr_cnt;
                wd_nxt = BG_COLOR;
                if (clr_cnt == '0) state_nxt = S_IDLE;
                else               clr_nxt   = clr_cnt - AW'(1);
            end
            S_IDLE: begin
                if (!touch_valid) begin
                    pen_nxt = 1'b0;
                end else if (in_range) begin
                    if (!pen_down) begin
                        we_nxt  = 1'b1;
                        wa_nxt  = touch_addr[AW-1:0];
                        wd_nxt  = INK_COLOR;
                        lx_nxt  = touch_x;
                        ly_nxt  = touch_y;
                        pen_nxt = 1'b1;
                    end else if (touch_x != last_x || touch_y != last_y) begin
                        cx_nxt    = last_x;
                        cy_nxt    = last_y;
                        ex_nxt    = touch_x;
                        ey_nxt    = touch_y;
                        dx_nxt    = adx;
                        dy_nxt    = ady;
                        sx_nxt    = (touch_x >= last_x) ? 2'b01 : 2'b11;
                        sy_nxt    = (touch_y >= last_y) ? 2'b01 : 2'b11;
                        err_nxt   = {adx[9], adx} - {ady[9], ady};
                        state_nxt = S_LINE;
                    end
                end
            end
            S_LINE: begin
                we_nxt = 1'b1;
                wa_nxt = cur_addr[AW-1:0];
                wd_nxt = INK_COLOR;
                if (cx == ex && cy == ey) begin
                    lx_nxt    = ex;
                    ly_nxt    = ey;
                    state_nxt = S_IDLE;
                end else begin
                    err_nxt = err_upd[10:0];
                    if (step_x) cx_nxt = cx + {{7{sx[1]}}, sx};
                    if (step_y) cy_nxt = cy + {{7{sy[1]}}, sy};
                end
            end
            default: state_nxt = S_CLEAR;
        endcase

        // Clear wins over everything; the cycle that takes it emits no write.
        if (clear) begin
            state_nxt = S_CLEAR;
            clr_nxt   = CLR_TOP;
            pen_nxt   = 1'b0;
            we_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state        <= S_CLEAR;
            clr_cnt      <= CLR_TOP;
            pen_down     <= 1'b0;
            last_x       <= '0;
            last_y       <= '0;
            cx           <= '0;
            cy           <= '0;
            ex           <= '0;
            ey           <= '0;
            dx           <= '0;
            dy           <= '0;
            sx           <= 2'b01;
            sy           <= 2'b01;
            err          <= '0;
            vram_wr_ena  <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
            busy         <= 1'b1;
        end else begin
            state        <= state_nxt;
            clr_cnt      <= clr_nxt;
            pen_down     <= pen_nxt;
            last_x       <= lx_nxt;
            last_y       <= ly_nxt;
            cx           <= cx_nxt;
            cy           <= cy_nxt;
            ex           <= ex_nxt;
            ey           <= ey_nxt;
            dx           <= dx_nxt;
            dy           <= dy_nxt;
            sx           <= sx_nxt;
            sy           <= sy_nxt;
            err          <= err_nxt;
            vram_wr_ena  <= we_nxt;
            vram_wr_addr <= wa_nxt;
            vram_wr_data <= wd_nxt;
            busy         <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_touch_stroke_renderer.sv
// Scoreboard bench for touch_stroke_renderer: expected writes (address, data, cycle, busy)
// are queued by a pixel-level model at stimulus time and checked by an output monitor.
module tb_touch_stroke_renderer;

    localparam int W   = 240;
    localparam int H   = 64;
    localparam int L   = W * H;
    localparam int AW  = $clog2(L);
    localparam int BG  = 16'h000F;
    localparam int INK = 16'hFC18;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          touch_valid = 1'b0;
    logic [8:0]    touch_x = '0;
    logic [8:0]    touch_y = '0;
    logic          clear = 1'b0;
    logic          vram_wr_ena;
    logic [AW-1:0] vram_wr_addr;
    logic [15:0]   vram_wr_data;
    logic          busy;

    touch_stroke_renderer #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)) dut (
        .clk(clk), .rstb(rstb), .touch_valid(touch_valid), .touch_x(touch_x),
        .touch_y(touch_y), .clear(clear), .vram_wr_ena(vram_wr_ena),
        .vram_wr_addr(vram_wr_addr), .vram_wr_data(vram_wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int at_cyc;
        bit busy;
    } exp_t;

    exp_t sb[$];
    int   px_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    bit   m_pen = 1'b0;
    int   m_lx = 0, m_ly = 0;

    function automatic void push(int a, int d, int at, bit b);
        exp_t e;
        e.addr = a; e.data = d; e.at_cyc = at; e.busy = b;
        sb.push_back(e);
    endfunction

    // Pixel list of a segment, endpoints inclusive, from the textbook integer algorithm.
    function automatic void gen_line(int x0, int y0, int x1, int y1);
        int ddx, ddy, sx, sy, er, e2, x, y;
        px_q.delete();
        ddx = (x1 > x0) ? x1 - x0 : x0 - x1;
        ddy = (y1 > y0) ? y1 - y0 : y0 - y1;
        sx  = (x1 >= x0) ? 1 : -1;
        sy  = (y1 >= y0) ? 1 : -1;
        er  = ddx - ddy;
        x = x0; y = y0;
        for (int i = 0; i < 1024; i++) begin
            px_q.push_back(y * W + x);
            if (x == x1 && y == y1) break;
            e2 = 2 * er;
            if (e2 > -ddy) begin er -= ddy; x += sx; end
            if (e2 < ddx)  begin er += ddx; y += sy; end
        end
    endfunction

    function automatic void push_fill(int first, int count);
        for (int i = 0; i < count; i++)
            push(L - 1 - i, BG, first + i, (L - 1 - i) != 0);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one touch sample and advance the model; waits out any resulting segment.
    task automatic apply(bit v, int x, int y, int hold);
        int s, n;
        @(negedge clk);
        touch_valid = v;
        touch_x = 9'(x);
        touch_y = 9'(y);
        s = cyc + 1;
        if (!v) begin
            m_pen = 1'b0;
        end else if (x < W && y < H) begin
            if (!m_pen) begin
                push(y * W + x, INK, s, 1'b0);
                m_pen = 1'b1; m_lx = x; m_ly = y;
            end else if (x != m_lx || y != m_ly) begin
                gen_line(m_lx, m_ly, x, y);
                n = px_q.size();
                for (int k = 0; k < n; k++) push(px_q[k], INK, s + 1 + k, k < n - 1);
                m_lx = x; m_ly = y;
                hold += n + 1;
            end
        end
        repeat (hold) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (vram_wr_ena === 1'b1) begin
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: addr %0d data %0h at cyc %0d, none expected",
                         vram_wr_addr, vram_wr_data, cyc);
            end else begin
                e = sb.pop_front();
                vectors++;
                if (vram_wr_addr !== e.addr[AW-1:0] || vram_wr_data !== e.data[15:0] ||
                    cyc != e.at_cyc || busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL vram_write: got addr %0d data %0h cyc %0d busy %b, expected addr %0d data %0h cyc %0d busy %b",
                             vram_wr_addr, vram_wr_data, cyc, busy, e.addr, e.data, e.at_cyc, e.busy);
                end
            end
        end
    end

    initial begin
        int r, x, y, m, j, s, cc, hold;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_wr_ena", 32'(vram_wr_ena), 32'd0);
        chk("reset_wr_addr", 32'(vram_wr_addr), 32'd0);
        chk("reset_wr_data", 32'(vram_wr_data), 32'd0);

        // Fill after reset release
        rstb = 1'b1;
        push_fill(cyc + 1, L);
        repeat (L / 2) @(negedge clk);
        chk("busy_mid_fill", 32'(busy), 32'd1);
        repeat (L / 2 + 2) @(negedge clk);
        chk("busy_after_fill", 32'(busy), 32'd0);

        // Dot held, then horizontal segment
        apply(1, 10, 20, 100);
        apply(1, 15, 20, 2);
        // Steep and diagonal segments after pen lifts
        apply(0, 0, 0, 1);
        apply(1, 5, 0, 2);
        apply(1, 6, 4, 2);
        apply(0, 0, 0, 1);
        apply(1, 0, 0, 2);
        apply(1, 3, 3, 2);
        // Isolated dots separated by a one-cycle lift
        apply(0, 0, 0, 1);
        apply(1, 10, 20, 2);
        apply(0, 0, 0, 1);
        apply(1, 50, 60, 2);
        // Out-of-range samples keep pen and last point
        apply(1, 240, 5, 3);
        apply(1, 5, 64, 3);
        apply(1, 52, 61, 2);
        chk("busy_idle", 32'(busy), 32'd0);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            hold = $urandom_range(1, 4);
            if (r == 0) begin
                apply(0, 0, 0, hold);
            end else if (r == 1) begin
                if ($urandom_range(0, 1) == 1) apply(1, $urandom_range(W, 511), $urandom_range(0, H - 1), hold);
                else                           apply(1, $urandom_range(0, W - 1), $urandom_range(H, 511), hold);
            end else if (r < 6) begin
                x = m_lx + $urandom_range(0, 16) - 8;
                y = m_ly + $urandom_range(0, 16) - 8;
                x = (x < 0) ? 0 : (x > W - 1) ? W - 1 : x;
                y = (y < 0) ? 0 : (y > H - 1) ? H - 1 : y;
                apply(1, x, y, hold);
            end else begin
                apply(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), hold);
            end
        end

        // Clear mid-segment, then clear again mid-fill
        apply(0, 0, 0, 1);
        apply(1, 0, 0, 2);
        @(negedge clk);
        touch_x = 9'd200;
        touch_y = 9'd0;
        s = cyc + 1;
        gen_line(0, 0, 200, 0);
        m = $urandom_range(3, 50);
        for (int k = 0; k < m; k++) push(px_q[k], INK, s + 1 + k, 1'b1);
        repeat (m + 1) @(negedge clk);
        clear = 1'b1;
        touch_valid = 1'b0;
        cc = cyc + 1;
        m_pen = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        chk("busy_after_clear", 32'(busy), 32'd1);
        j = $urandom_range(5, 40);
        push_fill(cc + 1, j);
        repeat (j) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        push_fill(cc + j + 2, L);
        repeat (L + 2) @(negedge clk);
        chk("busy_after_refill", 32'(busy), 32'd0);

        // Pen was lifted by the clear: a dot, not a segment
        apply(1, 7, 7, 3);
        apply(1, 9, 7, 2);

        repeat (5) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes: %0d expected writes never appeared", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
